// File: rtl/pll_reset_ctrl_pkg.sv
// Shared types and constants for the PLL reset/lock controller.
package pll_reset_ctrl_pkg;

   // Controller states; 3-bit encoding leaves room without widening the register.
   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } state_t;

   localparam int RETRY_W    = 4;
   localparam int LOSS_CNT_W = 8;

   // Width of the shared phase counter: enough bits to reach the largest
   // terminal count (value-1) among the three timed phases, never less than 1.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer, cleared to 0 by a synchronous reset.
module sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Shift the asynchronous input through the flop chain.
   // NOTE: non-blocking assignments so every stage samples the previous
   // stage's old value on the same edge; blocking would collapse the chain.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], d};
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout and
// bounded retries, qualifies lock as stable, then releases the system reset.
// Re-resets the PLL on lock loss or on request. Runs on the free-running refclk.
// Optional build macro PLL_RESET_CTRL_LOSS_CNT_EN adds a saturating count of
// lock-loss events on output lock_loss_cnt.
module pll_reset_ctrl
   import pll_reset_ctrl_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int LOCK_STABLE_CYCLES  = 256,
   parameter int MAX_RETRIES         = 3,
   parameter int SYNC_STAGES         = 2
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               pll_locked,
   input  logic               relock_req,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic               fail,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic               lock_lost
`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
   ,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

   localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

   localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               lock_lost_q, lock_lost_d;
   logic               locked_s;

   sync_bit #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // State, phase counter, retry count and sticky loss flag.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q     <= RESET_PLL;
         cnt_q       <= '0;
         retry_q     <= '0;
         lock_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         lock_lost_q <= lock_lost_d;
      end
   end

   // Next-state logic; the phase counter is cleared on every state change.
   always_comb begin
      // NOTE: every variable gets a hold value before the case so no path
      // leaves one unassigned, which would infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      retry_d     = retry_q;
      lock_lost_d = lock_lost_q;
      case (state_q)
         RESET_PLL: begin
            if (cnt_q == RST_LAST) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               cnt_d = '0;
               if (retry_q == RETRY_LIMIT) begin
                  state_d = FAIL;
               end else begin
                  state_d = RESET_PLL;
                  retry_d = retry_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STABLE: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
               retry_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            // Lock loss wins over a coincident relock request so it is recorded.
            if (!locked_s) begin
               state_d     = RESET_PLL;
               lock_lost_d = 1'b1;
            end else if (relock_req) begin
               state_d = RESET_PLL;
            end
         end
         FAIL: begin
            if (relock_req) begin
               state_d = RESET_PLL;
               retry_d = '0;
            end
         end
         default: begin
            state_d = RESET_PLL;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decode the state register only, so they move on the state edge.
   assign pll_rst   = (state_q == RESET_PLL);
   assign sys_rst   = (state_q != RUN);
   assign ready     = (state_q == RUN);
   assign fail      = (state_q == FAIL);
   assign retry_cnt = retry_q;
   assign lock_lost = lock_lost_q;

`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
   logic [LOSS_CNT_W-1:0] loss_cnt_q;
   logic                  loss_event;

   // Only a lock-loss exit from RUN counts; relock requests do not.
   assign loss_event = (state_q == RUN) && !locked_s;

   // Saturating lock-loss event counter.
   always_ff @(posedge refclk) begin
      if (rst) begin
         loss_cnt_q <= '0;
      end else if (loss_event && (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
         loss_cnt_q <= loss_cnt_q + 1'b1;
      end
   end

   assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: doc/pll_reset_ctrl.md
Name: pll_reset_ctrl

Overview:
- Controller at the far end of the PLL reset/lock interface: drives the PLL's `rst` and consumes its asynchronous `locked`.
- Pulses PLL reset and waits for lock with timeout and bounded retries.
- Qualifies lock as stable before releasing the downstream system reset.
- Re-resets the PLL on lock loss.
- Runs on the free-running `refclk`, because `outclk_0` is untrusted until lock.

Parameters:
- RST_PULSE_CYCLES, 16, refclk cycles `pll_rst` is held high per reset attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 50000, refclk cycles allowed for lock after `pll_rst` deasserts (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 256, consecutive synchronized-locked cycles required before release (>=1).
- MAX_RETRIES, 3, reset retries after the first attempt before declaring failure (0..15).
- SYNC_STAGES, 2, flops in the `pll_locked` synchronizer (>=2).

Ports:
- refclk  in  1  controller clock, free-running reference
- rst  in  1  synchronous active-high reset
- pll_locked  in  1  PLL lock indication, asynchronous to refclk
- relock_req  in  1  single-cycle request to force a PLL reset, refclk domain
- pll_rst  out  1  reset to PLL, active-high
- sys_rst  out  1  downstream reset, active-high, deasserts only once lock is stable
- ready  out  1  high only in RUN
- fail  out  1  high only in FAIL
- retry_cnt  out  4  retries consumed in the current acquisition
- lock_lost  out  1  sticky: lock dropped while in RUN; cleared by rst only

Behaviour:
- Reset values while rst=1, and one cycle after:
  - state RESET_PLL, pll_rst=1, sys_rst=1
  - ready=0, fail=0, retry_cnt=0, lock_lost=0
  - all counters 0
- Priority: rst has priority over every event.
- Registering: all outputs are registered and decoded from the state register; no combinational paths from inputs.
- locked_s is `pll_locked` after SYNC_STAGES flops. Only locked_s is used internally.
- RESET_PLL:
  - pll_rst=1, sys_rst=1.
  - Counter runs 0..RST_PULSE_CYCLES-1, then WAIT_LOCK; counter clears.
  - locked_s and relock_req are ignored.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - If locked_s=1, go to STABLE and clear the counter.
  - Otherwise the counter increments. At LOCK_TIMEOUT_CYCLES-1:
    - if retry_cnt==MAX_RETRIES, go to FAIL;
    - else increment retry_cnt and go to RESET_PLL.
- STABLE:
  - pll_rst=0, sys_rst=1.
  - If locked_s=0, return to WAIT_LOCK with a fresh timeout; retry_cnt unchanged.
  - Otherwise the counter increments. When it reaches LOCK_STABLE_CYCLES-1 with locked_s=1, go to RUN.
- RUN:
  - pll_rst=0, sys_rst=0, ready=1.
  - retry_cnt clears on entry.
  - If locked_s=0, go to RESET_PLL and set lock_lost.
  - Else if relock_req=1, go to RESET_PLL.
  - If both occur in the same cycle, go to RESET_PLL and set lock_lost.
- FAIL:
  - pll_rst=0, sys_rst=1, fail=1.
  - relock_req clears retry_cnt and goes to RESET_PLL.
  - Otherwise stays until rst.
- relock_req is ignored in RESET_PLL, WAIT_LOCK and STABLE.
- sys_rst and pll_rst change only on the clock edge that updates state; sys_rst never glitches low outside RUN.
- Counter width is $clog2 of the largest count parameter. Terminal compares use that width; no wrap-around is reachable.
- Latency: with `pll_locked` rising while in WAIT_LOCK, ready rises exactly SYNC_STAGES + LOCK_STABLE_CYCLES + 1 cycles after the first refclk edge sampling pll_locked=1.
- Mid-operation rst restarts the full sequence, with pll_rst high from the cycle after rst is sampled.

Optional Feature:
- PLL_RESET_CTRL_LOSS_CNT_EN defined:
  - adds output `lock_loss_cnt[7:0]`, reset to 0;
  - increments on each RUN to RESET_PLL transition caused by locked_s=0;
  - saturates at 255; relock_req-caused exits do not count.
- Undefined: the port and counter are absent; lock_lost is still present.

Decomposition:
- Package `pll_reset_ctrl_pkg` holds:
  - state enum (RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL), 3-bit encoding;
  - counter-width helper function;
  - retry_cnt width constant (4).
- Sub-module `sync_bit`: parameterized SYNC_STAGES flop chain, reset to 0, used for pll_locked.

Test Plan:
Sim parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, LOCK_STABLE_CYCLES=16, MAX_RETRIES=2, SYNC_STAGES=2.
- Nominal lock: release rst; pll_rst high 4 cycles; drive pll_locked=1 30 cycles later -> ready=1 and sys_rst=0 exactly 19 cycles after the first sampled locked; retry_cnt=0.
- Timeout/retry/fail: hold pll_locked=0 -> three pll_rst pulses of 4 cycles, 100 cycles apart; retry_cnt 0→1→2; then fail=1, pll_rst=0, sys_rst=1; relock_req -> retry_cnt=0, new pll_rst pulse.
- Unstable lock: pll_locked high 10 cycles, low 1 cycle, then high -> no ready during the glitch; ready 19 cycles after the final rise; retry_cnt unchanged.
- Lock loss in RUN: drop pll_locked -> sys_rst=1 and ready=0 SYNC_STAGES+1 cycles later, pll_rst pulse, lock_lost=1 and stays 1 after relock; loss counter=1 when macro defined.
- Simultaneous/mid-operation: relock_req and locked drop in the same RUN cycle -> single RESET_PLL entry, lock_lost=1; rst asserted mid-WAIT_LOCK -> all outputs at reset values the next cycle.
